// File: rtl/sgm_pkg.sv
// ---------------------------------------------------------------------------
// sgm_pkg
//   Shared constants for the simple_sgm disparity pipeline and its users
//   (half_img, disparity_median3x3). No ports.
//   A pipeline word is {de, h_sync, v_sync, pixel}. The *_BIT constants give
//   the field positions for the default pixel width.
// ---------------------------------------------------------------------------
package sgm_pkg;

  localparam int PX_W            = 8;
  localparam int DISPARITY_RANGE = 64;
  localparam int IMG_WIDTH       = 1280;
  localparam int HALF_IMG_WIDTH  = IMG_WIDTH / 2;
  localparam int H_TOTAL_HALF    = 832;

  // Word field positions: pixel occupies [PX_W-1:0], then vs, hs, de.
  localparam int VS_BIT = PX_W;
  localparam int HS_BIT = PX_W + 1;
  localparam int DE_BIT = PX_W + 2;
  localparam int WORD_W = PX_W + 3;

  typedef logic [WORD_W-1:0] sgm_word_t;

endpackage

// File: rtl/disparity_median3x3_sort3.sv
// ---------------------------------------------------------------------------
// sort3
//   Combinational unsigned sort of three W-bit values.
//   Ports:
//     i_a, i_b, i_c  in   W  values to sort (order irrelevant)
//     o_lo           out  W  minimum
//     o_mid          out  W  median
//     o_hi           out  W  maximum
//   Equal inputs are legal; the outputs are values, so ties need no ordering.
// ---------------------------------------------------------------------------
module sort3 #(
  parameter int W = sgm_pkg::PX_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_lo,
  output logic [W-1:0] o_mid,
  output logic [W-1:0] o_hi
);

  logic [W-1:0] w_ab_lo;
  logic [W-1:0] w_ab_hi;
  logic [W-1:0] w_abhi_c_lo;

  // Order a/b first, then place c against that pair.
  always_comb begin
    w_ab_lo     = (i_a < i_b) ? i_a : i_b;
    w_ab_hi     = (i_a < i_b) ? i_b : i_a;
    w_abhi_c_lo = (w_ab_hi < i_c) ? w_ab_hi : i_c;
    o_lo        = (w_ab_lo < i_c) ? w_ab_lo : i_c;
    o_hi        = (w_ab_hi < i_c) ? i_c : w_ab_hi;
    // Median is the larger of the pair minimum and min(pair maximum, c).
    o_mid       = (w_ab_lo < w_abhi_c_lo) ? w_abhi_c_lo : w_ab_lo;
  end

endmodule

// File: rtl/disparity_median3x3.sv
// ---------------------------------------------------------------------------
// disparity_median3x3
//   3x3 median post-filter on the 8-bit disparity stream (sgm_pclk domain).
//   Video timing travels with every pixel so the output stays frame-aligned.
//   Latency from input to output is H_TOTAL+4 clocks for pixel and syncs.
//   Parameters:
//     H_TOTAL  clocks per line including blanking (line delay depth)
//     PX_W     disparity pixel width
//   Ports:
//     clk          in   1     pixel clock
//     rst_n        in   1     asynchronous active-low reset
//     de_in        in   1     data enable
//     h_sync_in    in   1     horizontal sync (any polarity)
//     v_sync_in    in   1     vertical sync (any polarity)
//     pixel_in     in   PX_W  disparity
//     bypass       in   1     only with MEDIAN_BYPASS_PORT_EN: pass centre px
//     de_out       out  1     de of the window centre
//     h_sync_out   out  1     delayed h_sync
//     v_sync_out   out  1     delayed v_sync
//     pixel_out    out  PX_W  filtered disparity
//   Build option: define MEDIAN_BYPASS_PORT_EN to add the bypass port.
//   Borders: if any of the nine window de bits is low, the centre pixel is
//   passed unfiltered, which handles the first/last row and column without
//   position counters. Outputs are forced to 0 until the pipeline has been
//   refilled after reset, hiding stale line-delay RAM contents.
// ---------------------------------------------------------------------------
module disparity_median3x3 #(
  parameter int H_TOTAL = sgm_pkg::H_TOTAL_HALF,
  parameter int PX_W    = sgm_pkg::PX_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            de_in,
  input  logic            h_sync_in,
  input  logic            v_sync_in,
  input  logic [PX_W-1:0] pixel_in,
`ifdef MEDIAN_BYPASS_PORT_EN
  input  logic            bypass,
`endif
  output logic            de_out,
  output logic            h_sync_out,
  output logic            v_sync_out,
  output logic [PX_W-1:0] pixel_out
);

  import sgm_pkg::*;

  localparam int WW       = PX_W + 3;
  // Package indices assume the package pixel width; rebase onto PX_W.
  localparam int I_VS     = VS_BIT - sgm_pkg::PX_W + PX_W;
  localparam int I_HS     = HS_BIT - sgm_pkg::PX_W + PX_W;
  localparam int I_DE     = DE_BIT - sgm_pkg::PX_W + PX_W;
  localparam int PTR_W    = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int FILL_MAX = 2 * H_TOTAL + 4;
  localparam int FILL_W   = $clog2(FILL_MAX + 1);

  logic             w_bypass;
  logic [WW-1:0]    w_tap [3];       // row0 = input, row1/row2 = line delays
  logic [WW-1:0]    r_win_a [3];     // centre column of the window
  logic [WW-1:0]    r_win_b [3];     // oldest column of the window
  logic [WW-1:0]    w_col [3][3];    // [column][row], column 0 is newest
  logic             w_all_de;

  logic [PX_W-1:0]  w_s1_lo [3];
  logic [PX_W-1:0]  w_s1_mid [3];
  logic [PX_W-1:0]  w_s1_hi [3];
  logic [PX_W-1:0]  r_s1_lo [3];
  logic [PX_W-1:0]  r_s1_mid [3];
  logic [PX_W-1:0]  r_s1_hi [3];
  logic [WW-1:0]    r_s1_ctr;
  logic             r_s1_flt;

  logic [PX_W-1:0]  w_s2_max_lo;
  logic [PX_W-1:0]  w_s2_med_mid;
  logic [PX_W-1:0]  w_s2_min_hi;
  logic [PX_W-1:0]  r_s2_max_lo;
  logic [PX_W-1:0]  r_s2_med_mid;
  logic [PX_W-1:0]  r_s2_min_hi;
  logic [WW-1:0]    r_s2_ctr;
  logic             r_s2_flt;

  logic [PX_W-1:0]  w_s3_med;
  logic [PX_W-1:0]  w_unused_px [8];
  logic [FILL_W-1:0] r_fill;
  logic             w_filled;

`ifdef MEDIAN_BYPASS_PORT_EN
  assign w_bypass = bypass;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_tap[0] = {de_in, h_sync_in, v_sync_in, pixel_in};

  // Two cascaded line delays. Read-before-write at a free-running pointer
  // gives exactly H_TOTAL clocks between a word's write and its read.
  for (genvar g = 0; g < 2; g++) begin : g_line
    logic [WW-1:0]    r_mem [H_TOTAL];
    logic [PTR_W-1:0] r_ptr;

    assign w_tap[g+1] = r_mem[r_ptr];

    // RAM write; contents are not reset, the fill gate masks them.
    always_ff @(posedge clk) begin
      r_mem[r_ptr] <= w_tap[g];
    end

    // Pointer 0..H_TOTAL-1, wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_ptr <= '0;
      end else if (r_ptr == PTR_W'(H_TOTAL - 1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= r_ptr + PTR_W'(1);
      end
    end
  end

  // Two-register column chain per row; with the tap this forms the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        r_win_a[r] <= '0;
        r_win_b[r] <= '0;
      end
    end else begin
      for (int r = 0; r < 3; r++) begin
        r_win_a[r] <= w_tap[r];
        r_win_b[r] <= r_win_a[r];
      end
    end
  end

  // Window view and the border flag (all nine de bits high).
  always_comb begin
    w_all_de = 1'b1;
    for (int r = 0; r < 3; r++) begin
      w_col[0][r] = w_tap[r];
      w_col[1][r] = r_win_a[r];
      w_col[2][r] = r_win_b[r];
    end
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 3; r++) begin
        w_all_de = w_all_de & w_col[c][r][I_DE];
      end
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_s1
    sort3 #(.W(PX_W)) u_sort (
      .i_a   (w_col[c][0][PX_W-1:0]),
      .i_b   (w_col[c][1][PX_W-1:0]),
      .i_c   (w_col[c][2][PX_W-1:0]),
      .o_lo  (w_s1_lo[c]),
      .o_mid (w_s1_mid[c]),
      .o_hi  (w_s1_hi[c])
    );
  end

  // Stage 1: sorted columns, centre word, and the filter-enable decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        r_s1_lo[c]  <= '0;
        r_s1_mid[c] <= '0;
        r_s1_hi[c]  <= '0;
      end
      r_s1_ctr <= '0;
      r_s1_flt <= 1'b0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        r_s1_lo[c]  <= w_s1_lo[c];
        r_s1_mid[c] <= w_s1_mid[c];
        r_s1_hi[c]  <= w_s1_hi[c];
      end
      r_s1_ctr <= w_col[1][1];
      r_s1_flt <= w_all_de & ~w_bypass;
    end
  end

  // Max of the column minima, median of medians, min of the column maxima.
  sort3 #(.W(PX_W)) u_s2_lo (
    .i_a(r_s1_lo[0]), .i_b(r_s1_lo[1]), .i_c(r_s1_lo[2]),
    .o_lo(w_unused_px[0]), .o_mid(w_unused_px[1]), .o_hi(w_s2_max_lo)
  );
  sort3 #(.W(PX_W)) u_s2_mid (
    .i_a(r_s1_mid[0]), .i_b(r_s1_mid[1]), .i_c(r_s1_mid[2]),
    .o_lo(w_unused_px[2]), .o_mid(w_s2_med_mid), .o_hi(w_unused_px[3])
  );
  sort3 #(.W(PX_W)) u_s2_hi (
    .i_a(r_s1_hi[0]), .i_b(r_s1_hi[1]), .i_c(r_s1_hi[2]),
    .o_lo(w_s2_min_hi), .o_mid(w_unused_px[4]), .o_hi(w_unused_px[5])
  );

  // Stage 2: the three candidates whose median is the 3x3 median.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_max_lo  <= '0;
      r_s2_med_mid <= '0;
      r_s2_min_hi  <= '0;
      r_s2_ctr     <= '0;
      r_s2_flt     <= 1'b0;
    end else begin
      r_s2_max_lo  <= w_s2_max_lo;
      r_s2_med_mid <= w_s2_med_mid;
      r_s2_min_hi  <= w_s2_min_hi;
      r_s2_ctr     <= r_s1_ctr;
      r_s2_flt     <= r_s1_flt;
    end
  end

  sort3 #(.W(PX_W)) u_s3 (
    .i_a(r_s2_max_lo), .i_b(r_s2_med_mid), .i_c(r_s2_min_hi),
    .o_lo(w_unused_px[6]), .o_mid(w_s3_med), .o_hi(w_unused_px[7])
  );

  // Fill counter: saturates once every pipeline stage holds post-reset data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill <= '0;
    end else if (r_fill != FILL_W'(FILL_MAX)) begin
      r_fill <= r_fill + FILL_W'(1);
    end else begin
      r_fill <= r_fill;
    end
  end

  assign w_filled = (r_fill == FILL_W'(FILL_MAX));

  // Stage 3 / outputs: median or centre pixel, zero until the fill completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_out     <= 1'b0;
      h_sync_out <= 1'b0;
      v_sync_out <= 1'b0;
      pixel_out  <= '0;
    end else if (w_filled) begin
      de_out     <= r_s2_ctr[I_DE];
      h_sync_out <= r_s2_ctr[I_HS];
      v_sync_out <= r_s2_ctr[I_VS];
      pixel_out  <= r_s2_flt ? w_s3_med : r_s2_ctr[PX_W-1:0];
    end else begin
      de_out     <= 1'b0;
      h_sync_out <= 1'b0;
      v_sync_out <= 1'b0;
      pixel_out  <= '0;
    end
  end

endmodule

// File: tb/tb_disparity_median3x3.sv
// ---------------------------------------------------------------------------
// tb_disparity_median3x3
//   Directed frames (H_TOTAL=16, 10 active px, 8 active lines, 10 lines per
//   frame) with a sorting reference model of the 3x3 median, the border rule,
//   the fill gate and the 20-clock delay, plus hand-computed spot values.
// ---------------------------------------------------------------------------
module tb_disparity_median3x3;

  localparam int H    = 16;
  localparam int LAT  = H + 4;
  localparam int FILL = 2 * H + 4;
  localparam int NH   = 4096;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       de_in;
  logic       h_sync_in;
  logic       v_sync_in;
  logic [7:0] pixel_in;
  logic       bypass;
  logic       de_out;
  logic       h_sync_out;
  logic       v_sync_out;
  logic [7:0] pixel_out;

  logic [10:0] hist [NH];     // word applied before edge n since reset release
  logic        byp_hist [NH];
  int          spot [NH];     // hand-computed filtered value for a centre, or -1
  int          n;
  int          checks = 0;
  int          passes = 0;

  always #5 clk = ~clk;

  disparity_median3x3 #(.H_TOTAL(H), .PX_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .de_in      (de_in),
    .h_sync_in  (h_sync_in),
    .v_sync_in  (v_sync_in),
    .pixel_in   (pixel_in),
`ifdef MEDIAN_BYPASS_PORT_EN
    .bypass     (bypass),
`endif
    .de_out     (de_out),
    .h_sync_out (h_sync_out),
    .v_sync_out (v_sync_out),
    .pixel_out  (pixel_out)
  );

  // Expected {de,hs,vs,px} just after edge k.
  function automatic logic [10:0] model(input int k);
    logic [7:0]  v [9];
    logic [7:0]  t;
    logic [10:0] w;
    logic        all_de;
    int          b;
    int          m;
    if (k <= FILL) return 11'd0;
    b = k - LAT + 1;
    all_de = 1'b1;
    m = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        w = hist[b + dr * H + dc];
        all_de = all_de & w[10];
        v[m] = w[7:0];
        m++;
      end
    end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8 - i; j++) begin
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
      end
    end
    w = hist[b];
    if (all_de && !byp_hist[k-2]) w[7:0] = v[4];
    return w;
  endfunction

  function automatic logic [7:0] pat(input int l, input int c);
    logic [71:0] a;
    int e;
    a = {8'd9, 8'd2, 8'd7, 8'd4, 8'd1, 8'd8, 8'd3, 8'd6, 8'd5};
    if (l >= 1 && l <= 3 && c >= 2 && c <= 4) begin
      e = (l - 1) * 3 + (c - 2);
      return a[8*(8-e) +: 8];
    end
    if (l == 4 && c >= 5 && c <= 7) return 8'd7;
    if (l == 6 && c >= 5 && c <= 7) return 8'd9;
    return 8'd0;
  endfunction

  task automatic check_out();
    logic [10:0] got;
    logic [10:0] exp;
    int b;
    got = {de_out, h_sync_out, v_sync_out, pixel_out};
    exp = model(n);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL stream k=%0d observed=%h expected=%h", n, got, exp);
    b = n - LAT + 1;
    if (n > FILL && spot[b] >= 0) begin
      checks++;
      assert ({de_out, pixel_out} === {1'b1, 8'(spot[b])}) passes++;
      else $error("FAIL spot k=%0d observed de=%b px=%0d expected px=%0d", n, de_out, pixel_out, spot[b]);
    end
  endtask

  task automatic step(input logic de, input logic hs, input logic vs, input logic [7:0] px, input int sp);
    de_in = de; h_sync_in = hs; v_sync_in = vs; pixel_in = px;
    n++;
    hist[n] = {de, hs, vs, px};
    byp_hist[n] = bypass;
    spot[n] = sp;
    @(posedge clk);
    #1;
    check_out();
  endtask

  // md: 0 const 20, 1 interior impulse, 2 border impulse, 3 patterns, 4 noise
  task automatic frame(input int md, input logic act_low, input int nlines, input logic tgl);
    logic       de;
    logic       hs;
    logic       vs;
    logic [7:0] px;
    int         sp;
    for (int l = 0; l < nlines; l++) begin
      if (tgl) bypass = l[0];
      for (int c = 0; c < H; c++) begin
        de = (l < 8) && (c < 10);
        hs = ((c == 12) || (c == 13)) ^ act_low;
        vs = (l == 9) ^ act_low;
        px = 8'd0;
        sp = -1;
        if (de) begin
          case (md)
            0: begin px = 8'd20; sp = 20; end
            1: begin px = (l == 3 && c == 5) ? 8'd63 : 8'd0; sp = 0; end
            2: begin px = (l == 0 && c == 5) ? 8'd63 : 8'd0; sp = (l == 0 && c == 5) ? 63 : -1; end
            3: begin px = pat(l, c); sp = (l == 2 && c == 3) ? 5 : ((l == 5 && c == 6) ? 7 : -1); end
            default: px = 8'($urandom_range(0, 255));
          endcase
        end
        step(de, hs, vs, px, sp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; de_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0;
    pixel_in = 8'd0; bypass = 1'b0; n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert ({de_out, h_sync_out, v_sync_out, pixel_out} === 11'd0) passes++;
    else $error("FAIL reset_state observed=%h expected=0", {de_out, h_sync_out, v_sync_out, pixel_out});
    rst_n = 1'b1;
    n = 0;

    frame(0, 1'b0, 10, 1'b0);   // fill, then constant 20
    frame(0, 1'b0, 10, 1'b0);
    frame(1, 1'b0, 10, 1'b0);   // interior impulse removed
    frame(2, 1'b0, 10, 1'b0);   // border impulse kept
    frame(3, 1'b0, 10, 1'b0);   // 1..9 scrambled -> 5, {7,7,7,0,0,0,9,9,9} -> 7
    frame(4, 1'b1, 10, 1'b0);   // active-low syncs
    frame(4, 1'b1, 10, 1'b0);
    frame(4, 1'b0, 4, 1'b0);    // cut short by reset

    rst_n = 1'b0;
    #1;
    checks++;
    assert ({de_out, h_sync_out, v_sync_out, pixel_out} === 11'd0) passes++;
    else $error("FAIL async_reset observed=%h expected=0", {de_out, h_sync_out, v_sync_out, pixel_out});
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    frame(4, 1'b0, 10, 1'b0);   // refill: 36 clk of zeros, then model-exact
    frame(4, 1'b0, 10, 1'b0);
`ifdef MEDIAN_BYPASS_PORT_EN
    frame(4, 1'b0, 10, 1'b1);
    frame(4, 1'b0, 10, 1'b1);
    bypass = 1'b0;
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
